// File: rtl/rr_arb_pkg.sv
// Shared types, default parameters and width helper for the round-robin
// register write arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_HOLD = 4;

    // Bits needed to hold an index in [0, n-1]; never returns less than 1.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_reg_write_arbiter_pick.sv
// Combinational circular priority picker: first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Conditional subtract instead of modulo keeps non-power-of-two NUM_REQ
    // in range without building a divider.
    function automatic int wrap_add(input int base, input int off);
        int sum;
        sum = base + off;
        return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
    endfunction

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!any && req[wrap_add(int'(ptr), off)]) begin
                any                             = 1'b1;
                idx                             = IDX_W'(wrap_add(int'(ptr), off));
                onehot[wrap_add(int'(ptr), off)] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter sharing one DATA_W-bit register between NUM_REQ
// requesters, with an optional lock bounded by MAX_HOLD back-to-back writes.
module rr_reg_write_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*DATA_W-1:0]   wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]           q,
    output logic [idx_w(NUM_REQ)-1:0]   q_owner,
    output logic                        wr_strobe,
    output logic                        busy
);

    localparam int IDX_W  = idx_w(NUM_REQ);
    localparam int HOLD_W = idx_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_e           state_q,     state_d;
    logic [IDX_W-1:0]     ptr_q,       ptr_d;
    logic [IDX_W-1:0]     owner_q,     owner_d;
    logic [HOLD_W-1:0]    hold_cnt_q,  hold_cnt_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic [DATA_W-1:0]    q_q,         q_d;
    logic [IDX_W-1:0]     q_owner_q,   q_owner_d;
    logic                 wr_strobe_q, wr_strobe_d;
    logic                 busy_q,      busy_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic [IDX_W-1:0]     owner_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    assign owner_next = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        q_d         = q_q;
        q_owner_d   = q_owner_q;
        wr_strobe_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    gnt_d      = pick_onehot;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end else begin
                    gnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_next;
                end else begin
                    q_d         = wdata[int'(owner_q)*DATA_W +: DATA_W];
                    q_owner_d   = owner_q;
                    wr_strobe_d = 1'b1;
                    // The lock only extends the grant while writes remain in budget.
                    if (lock[owner_q] && (hold_cnt_q < HOLD_LAST)) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end else begin
                        state_d    = IDLE;
                        gnt_d      = '0;
                        ptr_d      = owner_next;
                        hold_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d == GRANT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            q_q         <= '0;
            q_owner_q   <= '0;
            wr_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            q_q         <= q_d;
            q_owner_q   <= q_owner_d;
            wr_strobe_q <= wr_strobe_d;
            busy_q      <= busy_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q))
        else $error("grant is multi-hot");

    assign gnt       = gnt_q;
    assign q         = q_q;
    assign q_owner   = q_owner_q;
    assign wr_strobe = wr_strobe_q;
    assign busy      = busy_q;

endmodule : rr_reg_write_arbiter

// File: doc/rr_reg_write_arbiter.md
Name: rr_reg_write_arbiter

Overview:
Shares one DATA_W-bit storage register, built from the team's d_ff flops, between NUM_REQ requesters.
Arbitration is round-robin with a req/gnt handshake. An optional lock lets the current owner issue back-to-back writes, bounded by a MAX_HOLD timeout counter.
Sits between the requester blocks and the register. Its outputs are the registered value, the owner ID and a write strobe.

Parameters:
NUM_REQ, 4, number of requesters (at least 2)
DATA_W, 8, width of the shared register
MAX_HOLD, 4, maximum writes per grant while lock is held (at least 1)

Ports:
clk  in  1  single clock for the whole block; all flops update on its rising edge
rst_n  in  1  reset, synchronous and active-low
req  in  NUM_REQ  per-requester write request; held until granted
lock  in  NUM_REQ  per-requester request to keep the grant after a write
wdata  in  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  registered one-hot grant
q  out  DATA_W  shared register contents
q_owner  out  clog2(NUM_REQ)  index of the requester that last wrote q
wr_strobe  out  1  one-cycle pulse, high in the cycle q shows newly written data
busy  out  1  high while state is GRANT

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge of clk) overrides all other inputs. On that edge:
  - state=IDLE, ptr=0, hold_cnt=0
  - gnt=0, q=0, q_owner=0, wr_strobe=0, busy=0
- Reset in the middle of a grant drops the grant and performs no write.
- State machine: two states, IDLE and GRANT.
- IDLE:
  - If req is nonzero, the winner is the first set bit at or after ptr, searching circularly (ptr, ptr+1, ... wrapping at NUM_REQ-1 to 0).
  - Next edge: gnt = one-hot of the winner, owner = winner, hold_cnt=0, state=GRANT.
  - If req is 0, stay in IDLE with gnt=0.
- GRANT, with o = owner; evaluated at each edge:
  - req[o]=0: no write; state=IDLE, gnt=0, ptr=(o+1) mod NUM_REQ.
  - req[o]=1: write. q <= wdata[o], q_owner <= o, wr_strobe <= 1. Then:
    - if lock[o]=1 and hold_cnt < MAX_HOLD-1: stay in GRANT, hold_cnt += 1, gnt unchanged.
    - otherwise: state=IDLE, gnt=0, ptr=(o+1) mod NUM_REQ, hold_cnt=0.
- wr_strobe is 0 in every cycle that does not follow a write edge.
- Latency: req rises in cycle 0 → gnt high in cycle 1 → q/wr_strobe valid in cycle 2.
- Throughput:
  - Unlocked: one write per 2 cycles, because of the IDLE bubble between grants.
  - Locked: one write per cycle, up to MAX_HOLD consecutive writes.
- Requests from non-owners during GRANT are ignored; they are arbitrated in the next IDLE.
- lock is sampled only in GRANT; lock without req has no effect.
- MAX_HOLD=1 means lock never extends a grant.
- ptr wraps modulo NUM_REQ. Non-power-of-two NUM_REQ must be handled with no out-of-range index.
- gnt is always one-hot or zero, never multi-hot.

Decomposition:
- Package rr_arb_pkg holds:
  - state enum {IDLE, GRANT}
  - default parameter constants
  - the index-width helper, clog2(NUM_REQ)
- Sub-module rr_pick: combinational circular priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot result, index, any.
  - Instantiated once.
- q is stored in DATA_W d_ff instances, or in an equivalent always_ff.

Test Plan:
- Reset mid-grant: req=0010 held, assert rst_n=0 in the cycle gnt=0010 → next cycle gnt=0, q=00, wr_strobe=0, busy=0.
- Single request, NUM_REQ=4, DATA_W=8: req=0100, wdata[2]=8'hA5 → cycle 1 gnt=0100; cycle 2 q=A5, q_owner=2, wr_strobe=1, gnt=0.
- Round-robin fairness: req=1111 held → grants in order 0,1,2,3,0. q sequence follows each requester's wdata. Exactly one wr_strobe every 2 cycles.
- Lock timeout, MAX_HOLD=4: req[1]=lock[1]=1 held, req[3]=1 → 4 consecutive strobes with q_owner=1, then IDLE, then gnt=1000.
- Owner drops request: gnt=0001 while req[0] falls to 0 → no strobe, q unchanged, next grant goes to index 1 or above (ptr=1).
- Wrap-around: ptr=3, req=0011 → gnt=0001 (index 0 wins over index 1).
